// File: rtl/program_counter_stack.sv
// Fetch-stage program counter with stall, absolute load, relative branch, call and return.
// Call/return use a small LIFO return-address stack with registered empty/full flags and a sticky error bit.
module program_counter_stack #(
  parameter int WIDTH       = 16,
  parameter int STEP        = 1,
  parameter int RESET_VEC   = 0,
  parameter int STACK_DEPTH = 4,
  parameter int OFF_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             ld_sig,
  input  logic [WIDTH-1:0] ld_in,
  input  logic             br_sig,
  input  logic [OFF_W-1:0] br_off,
  input  logic             call_sig,
  input  logic             ret_sig,
  output logic [WIDTH-1:0] out,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);

  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] out_reg, out_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             err_reg, err_next;
  logic             empty_reg, full_reg;
  logic             push;

  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];

  logic [WIDTH-1:0] seq_addr;
  logic [WIDTH-1:0] br_addr;
  logic [CW-1:0]    count_inc;
  logic [CW-1:0]    count_dec;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             cnt_empty;
  logic             cnt_full;

  assign seq_addr  = out_reg + WIDTH'(STEP);
  // Branch is relative to the current PC, with the offset sign-extended to full width.
  assign br_addr   = out_reg + {{(WIDTH-OFF_W){br_off[OFF_W-1]}}, br_off};
  assign count_inc = count_reg + CW'(1);
  assign count_dec = count_reg - CW'(1);
  assign wr_idx    = count_reg[AW-1:0];
  assign rd_idx    = count_dec[AW-1:0];
  assign cnt_empty = (count_reg == '0);
  assign cnt_full  = (count_reg == CW'(STACK_DEPTH));

  always_comb begin
    out_next   = out_reg;
    count_next = count_reg;
    err_next   = err_reg;
    push       = 1'b0;
    if (!stall) begin
      if (ret_sig) begin
        if (!cnt_empty) begin
          out_next   = stack_mem[rd_idx];
          count_next = count_dec;
        end else begin
          out_next = seq_addr;
          err_next = 1'b1;
        end
      end else if (call_sig) begin
        out_next = ld_in;
        if (!cnt_full) begin
          push       = 1'b1;
          count_next = count_inc;
        end else begin
          err_next = 1'b1;
        end
      end else if (ld_sig) begin
        out_next = ld_in;
      end else if (br_sig) begin
        out_next = br_addr;
      end else begin
        out_next = seq_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg   <= WIDTH'(RESET_VEC);
      count_reg <= '0;
      err_reg   <= 1'b0;
      empty_reg <= 1'b1;
      full_reg  <= 1'b0;
    end else begin
      out_reg   <= out_next;
      count_reg <= count_next;
      err_reg   <= err_next;
      empty_reg <= (count_next == '0);
      full_reg  <= (count_next == CW'(STACK_DEPTH));
    end
  end

  // Stack storage needs no reset: entries above count are never read.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      stack_mem[wr_idx] <= seq_addr;
    end
  end

  assign out         = out_reg;
  assign stack_empty = empty_reg;
  assign stack_full  = full_reg;
  assign stack_err   = err_reg;

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack: reset, wrap, branch, call/return nesting,
// overflow/underflow, priority, stall and mid-sequence reset.
module tb_program_counter_stack;

  logic        clk = 1'b0;
  logic        rst, stall, ld_sig, br_sig, call_sig, ret_sig;
  logic [15:0] ld_in;
  logic [7:0]  br_off;
  logic [15:0] out;
  logic        stack_empty, stack_full, stack_err;

  int checks = 0;
  int errors = 0;

  program_counter_stack dut (
    .clk(clk), .rst(rst), .stall(stall), .ld_sig(ld_sig), .ld_in(ld_in),
    .br_sig(br_sig), .br_off(br_off), .call_sig(call_sig), .ret_sig(ret_sig),
    .out(out), .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 1'b0; stall = 1'b0; ld_sig = 1'b0; br_sig = 1'b0;
    call_sig = 1'b0; ret_sig = 1'b0; ld_in = '0; br_off = '0;
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL reset_out got %h want %h", out, 16'h0000); end
    checks++; if (stack_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", stack_empty); end
    checks++; if (stack_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", stack_full); end
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", stack_err); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (out !== 16'(i)) begin errors++; $display("FAIL advance_%0d got %h want %h", i, out, 16'(i)); end
    end
    checks++; if (stack_empty !== 1'b1 || stack_err !== 1'b0) begin errors++; $display("FAIL advance_flags got empty=%b err=%b want empty=1 err=0", stack_empty, stack_err); end
    $display("test_reset done out=%h", out);
  endtask

  task automatic test_wrap_branch();
    ld_in = 16'hFFFE; ld_sig = 1'b1; tick(); ld_sig = 1'b0;
    checks++; if (out !== 16'hFFFE) begin errors++; $display("FAIL load got %h want FFFE", out); end
    tick();
    checks++; if (out !== 16'hFFFF) begin errors++; $display("FAIL pre_wrap got %h want FFFF", out); end
    tick();
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL wrap got %h want 0000", out); end
    tick();
    checks++; if (out !== 16'h0001) begin errors++; $display("FAIL post_wrap got %h want 0001", out); end
    br_off = 8'hFD; br_sig = 1'b1; tick(); br_sig = 1'b0;
    checks++; if (out !== 16'hFFFE) begin errors++; $display("FAIL branch_neg got %h want FFFE", out); end
    br_off = 8'h10; br_sig = 1'b1; tick(); br_sig = 1'b0;
    checks++; if (out !== 16'h000E) begin errors++; $display("FAIL branch_pos got %h want 000E", out); end
    $display("test_wrap_branch done out=%h", out);
  endtask

  task automatic test_call_ret();
    ld_in = 16'h0010; ld_sig = 1'b1; tick(); ld_sig = 1'b0;
    ld_in = 16'h0100; call_sig = 1'b1; tick(); call_sig = 1'b0;
    checks++; if (out !== 16'h0100) begin errors++; $display("FAIL call1 got %h want 0100", out); end
    checks++; if (stack_empty !== 1'b0) begin errors++; $display("FAIL call1_empty got %b want 0", stack_empty); end
    tick();
    checks++; if (out !== 16'h0101) begin errors++; $display("FAIL call1_adv got %h want 0101", out); end
    ld_in = 16'h0200; call_sig = 1'b1; tick(); call_sig = 1'b0;
    checks++; if (out !== 16'h0200) begin errors++; $display("FAIL call2 got %h want 0200", out); end
    ret_sig = 1'b1; tick();
    checks++; if (out !== 16'h0102) begin errors++; $display("FAIL ret1 got %h want 0102", out); end
    tick(); ret_sig = 1'b0;
    checks++; if (out !== 16'h0011) begin errors++; $display("FAIL ret2 got %h want 0011", out); end
    checks++; if (stack_empty !== 1'b1 || stack_err !== 1'b0) begin errors++; $display("FAIL callret_flags got empty=%b err=%b want empty=1 err=0", stack_empty, stack_err); end
    $display("test_call_ret done out=%h", out);
  endtask

  task automatic test_overflow_underflow();
    logic [15:0] exp_ret [4];
    exp_ret = '{16'h3001, 16'h2001, 16'h1001, 16'h0012};
    for (int i = 1; i <= 5; i++) begin
      ld_in = 16'(i * 16'h1000); call_sig = 1'b1; tick(); call_sig = 1'b0;
      checks++; if (out !== 16'(i * 16'h1000)) begin errors++; $display("FAIL ovf_call%0d got %h want %h", i, out, 16'(i * 16'h1000)); end
      if (i == 3) begin
        checks++; if (stack_full !== 1'b0) begin errors++; $display("FAIL full_early got %b want 0", stack_full); end
      end
      if (i == 4) begin
        checks++; if (stack_full !== 1'b1 || stack_err !== 1'b0) begin errors++; $display("FAIL full4 got full=%b err=%b want full=1 err=0", stack_full, stack_err); end
      end
    end
    checks++; if (stack_err !== 1'b1 || stack_full !== 1'b1) begin errors++; $display("FAIL overflow got err=%b full=%b want err=1 full=1", stack_err, stack_full); end
    for (int i = 0; i < 4; i++) begin
      ret_sig = 1'b1; tick(); ret_sig = 1'b0;
      checks++; if (out !== exp_ret[i]) begin errors++; $display("FAIL ovf_ret%0d got %h want %h", i, out, exp_ret[i]); end
    end
    checks++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin errors++; $display("FAIL drained got empty=%b full=%b want 1/0", stack_empty, stack_full); end
    ret_sig = 1'b1; tick(); ret_sig = 1'b0;
    checks++; if (out !== 16'h0013) begin errors++; $display("FAIL underflow_out got %h want 0013", out); end
    checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL underflow_err got %b want 1", stack_err); end
    $display("test_overflow_underflow done out=%h", out);
  endtask

  task automatic test_priority_stall();
    do_reset();
    ld_in = 16'h0040; call_sig = 1'b1; tick();
    ld_in = 16'h0050; tick(); call_sig = 1'b0;
    ld_in = 16'h0077; ret_sig = 1'b1; call_sig = 1'b1; ld_sig = 1'b1; tick();
    ret_sig = 1'b0; call_sig = 1'b0; ld_sig = 1'b0;
    checks++; if (out !== 16'h0041) begin errors++; $display("FAIL prio_pop got %h want 0041", out); end
    checks++; if (stack_empty !== 1'b0 || stack_err !== 1'b0) begin errors++; $display("FAIL prio_flags got empty=%b err=%b want 0/0", stack_empty, stack_err); end
    ld_in = 16'h0099; ld_sig = 1'b1; stall = 1'b1; ret_sig = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out !== 16'h0041) begin errors++; $display("FAIL stall%0d got %h want 0041", i, out); end
    end
    stall = 1'b0; ld_sig = 1'b0; tick(); ret_sig = 1'b0;
    checks++; if (out !== 16'h0001 || stack_empty !== 1'b1) begin errors++; $display("FAIL post_stall got out=%h empty=%b want 0001/1", out, stack_empty); end
    ld_in = 16'h0123; br_off = 8'h05; ld_sig = 1'b1; br_sig = 1'b1; tick();
    ld_sig = 1'b0; br_sig = 1'b0;
    checks++; if (out !== 16'h0123) begin errors++; $display("FAIL ld_over_br got %h want 0123", out); end
    $display("test_priority_stall done out=%h", out);
  endtask

  task automatic test_reset_mid_op();
    ld_in = 16'h0300; call_sig = 1'b1; tick();
    ld_in = 16'h0400; tick(); call_sig = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (out !== 16'h0000 || stack_empty !== 1'b1 || stack_err !== 1'b0 || stack_full !== 1'b0) begin
      errors++; $display("FAIL midrst got out=%h empty=%b err=%b full=%b want 0000/1/0/0", out, stack_empty, stack_err, stack_full);
    end
    ret_sig = 1'b1; tick(); ret_sig = 1'b0;
    checks++; if (out !== 16'h0001 || stack_err !== 1'b1) begin errors++; $display("FAIL midrst_ret got out=%h err=%b want 0001/1", out, stack_err); end
    $display("test_reset_mid_op done out=%h", out);
  endtask

  initial begin
    idle();
    #2;
    test_reset();
    test_wrap_branch();
    test_call_ret();
    test_overflow_underflow();
    test_priority_stall();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
